// File: rtl/aes128_mixcol.sv
// Serial AES MixColumns / InvMixColumns engine for one 32-bit column, sharing one GF(2^8) multiplier.
// Define AES128_MIXCOL_INV_EN to build the inverse matrix; otherwise inv_i is ignored.
module aes128_mixcol #(
  parameter int unsigned BYPASS_ONE = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        inv_i,
  input  logic [31:0] col_i,
  output logic [31:0] col_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        mul_start_o,
  output logic [7:0]  mul_a_o,
  output logic [7:0]  mul_b_o,
  input  logic [7:0]  mul_result_i,
  input  logic        mul_valid_i
);

  typedef enum logic [1:0] {StIdle, StStep, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [31:0] col_q, col_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic [1:0]  r_q, r_d;
  logic [1:0]  k_q, k_d;

  logic [1:0]  diag;
  logic [7:0]  cur_coef;
  logic [7:0]  cur_byte;
  logic        bypass_hit;
  logic        mul_start;
  logic        advance;
  logic [7:0]  term;
  logic [7:0]  sum;
  logic        accept;

  // Both matrices are circulant: M[r][k] depends only on (k - r) mod 4.
  function automatic logic [7:0] fwd_coef(input logic [1:0] d);
    logic [7:0] c;
    unique case (d)
      2'd0: c = 8'h02;
      2'd1: c = 8'h03;
      2'd2: c = 8'h01;
      2'd3: c = 8'h01;
    endcase
    return c;
  endfunction

  assign diag   = k_q - r_q;
  assign accept = (state_q == StIdle) && start_i;

`ifdef AES128_MIXCOL_INV_EN
  logic inv_q, inv_d;

  function automatic logic [7:0] inv_coef(input logic [1:0] d);
    logic [7:0] c;
    unique case (d)
      2'd0: c = 8'h0E;
      2'd1: c = 8'h0B;
      2'd2: c = 8'h0D;
      2'd3: c = 8'h09;
    endcase
    return c;
  endfunction

  always_comb begin
    inv_d = inv_q;
    if (accept) inv_d = inv_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end

  assign cur_coef = inv_q ? inv_coef(diag) : fwd_coef(diag);
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign cur_coef   = fwd_coef(diag);
`endif

  always_comb begin
    unique case (k_q)
      2'd0: cur_byte = s_q[31:24];
      2'd1: cur_byte = s_q[23:16];
      2'd2: cur_byte = s_q[15:8];
      2'd3: cur_byte = s_q[7:0];
    endcase
  end

  assign bypass_hit = (BYPASS_ONE != 0) && (cur_coef == 8'h01);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    col_d     = col_q;
    acc_d     = acc_q;
    r_d       = r_q;
    k_d       = k_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_start = 1'b0;
    advance   = 1'b0;
    term      = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          s_d     = col_i;
          acc_d   = 8'h00;
          r_d     = 2'd0;
          k_d     = 2'd0;
          state_d = StStep;
        end
      end
      StStep: begin
        if (bypass_hit) begin
          term    = cur_byte;
          advance = 1'b1;
        end else begin
          mul_a_d   = cur_coef;
          mul_b_d   = cur_byte;
          mul_start = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mul_valid_i) begin
          term    = mul_result_i;
          advance = 1'b1;
          state_d = StStep;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    sum = acc_q ^ term;
    if (advance) begin
      if (k_q == 2'd3) begin
        unique case (r_q)
          2'd0: col_d[31:24] = sum;
          2'd1: col_d[23:16] = sum;
          2'd2: col_d[15:8]  = sum;
          2'd3: col_d[7:0]   = sum;
        endcase
        acc_d = 8'h00;
        k_d   = 2'd0;
        r_d   = r_q + 2'd1;
        if (r_q == 2'd3) state_d = StDone;
      end else begin
        acc_d = sum;
        k_d   = k_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      s_q     <= 32'h0;
      col_q   <= 32'h0;
      acc_q   <= 8'h00;
      mul_a_q <= 8'h00;
      mul_b_q <= 8'h00;
      r_q     <= 2'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  // Operands go out combinationally in the issuing cycle, then hold from the registers.
  assign mul_start_o = mul_start;
  assign mul_a_o     = mul_start ? cur_coef : mul_a_q;
  assign mul_b_o     = mul_start ? cur_byte : mul_b_q;
  assign col_o       = col_q;
  assign valid_o     = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);

  a_no_start_in_wait: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == StWait) |-> !mul_start_o);
  a_valid_implies_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    valid_o |-> busy_o);

endmodule

// File: tb/tb_aes128_mixcol.sv
// Randomized self-checking bench: two engines (bypass on/off) against a GF(2^8) reference model,
// each served by a behavioural multiplier with random latency and optional spurious valids.
module tb_aes128_mixcol;

`ifdef AES128_MIXCOL_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  localparam logic [7:0] MF [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                       '{8'h01, 8'h02, 8'h03, 8'h01},
                                       '{8'h01, 8'h01, 8'h02, 8'h03},
                                       '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] MI [4][4] = '{'{8'h0E, 8'h0B, 8'h0D, 8'h09},
                                       '{8'h09, 8'h0E, 8'h0B, 8'h0D},
                                       '{8'h0D, 8'h09, 8'h0E, 8'h0B},
                                       '{8'h0B, 8'h0D, 8'h09, 8'h0E}};

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        inv;
  logic [31:0] col;

  logic [31:0] col_w    [2];
  logic        valid_w  [2];
  logic        busy_w   [2];
  logic        mstart_w [2];
  logic [7:0]  ma_w     [2];
  logic [7:0]  mb_w     [2];
  logic [7:0]  mres     [2];
  logic        mval     [2];

  int          n_tests;
  int          n_fail;
  bit          spur_en;

  // Responder state, written only by the responder process.
  bit          pending  [2];
  int          lat      [2];
  logic [7:0]  pa       [2];
  logic [7:0]  pb       [2];
  int          starts   [2];
  int          valids   [2];
  int          a_hist   [2][16];
  int          overlap;
  int          unstable;
  int          oor;

  aes128_mixcol #(.BYPASS_ONE(0)) u_dut_mul (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .inv_i       (inv),
    .col_i       (col),
    .col_o       (col_w[0]),
    .valid_o     (valid_w[0]),
    .busy_o      (busy_w[0]),
    .mul_start_o (mstart_w[0]),
    .mul_a_o     (ma_w[0]),
    .mul_b_o     (mb_w[0]),
    .mul_result_i(mres[0]),
    .mul_valid_i (mval[0])
  );

  aes128_mixcol #(.BYPASS_ONE(1)) u_dut_byp (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .inv_i       (inv),
    .col_i       (col),
    .col_o       (col_w[1]),
    .valid_o     (valid_w[1]),
    .busy_o      (busy_w[1]),
    .mul_start_o (mstart_w[1]),
    .mul_a_o     (ma_w[1]),
    .mul_b_o     (mb_w[1]),
    .mul_result_i(mres[1]),
    .mul_valid_i (mval[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input bit iv, input int r, input int k);
    return iv ? MI[r][k] : MF[r][k];
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] c, input bit iv);
    logic [7:0] s [4];
    logic [7:0] o [4];
    s = '{c[31:24], c[23:16], c[15:8], c[7:0]};
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) o[r] = o[r] ^ gf_mul(coef(iv, r, k), s[k]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic int exp_starts(input bit byp, input bit iv);
    int n;
    n = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!byp || coef(iv, r, k) != 8'h01) n++;
    return n;
  endfunction

  function automatic logic [15:0] exp_mask(input bit byp, input bit iv);
    logic [15:0] m;
    m = 16'h0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!byp || coef(iv, r, k) != 8'h01) m[coef(iv, r, k)] = 1'b1;
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: samples requests on the falling edge, answers after a random delay.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        pending[g] = 1'b0;
        mval[g]    = 1'b0;
        mres[g]    = 8'h00;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        mval[g] = 1'b0;
        if (valid_w[g]) valids[g]++;
        if (pending[g]) begin
          if (mstart_w[g]) overlap++;
          if (ma_w[g] !== pa[g] || mb_w[g] !== pb[g]) unstable++;
          if (lat[g] == 0) begin
            mval[g]    = 1'b1;
            mres[g]    = gf_mul(pa[g], pb[g]);
            pending[g] = 1'b0;
          end else begin
            lat[g]--;
          end
        end else if (mstart_w[g]) begin
          pending[g] = 1'b1;
          pa[g]      = ma_w[g];
          pb[g]      = mb_w[g];
          lat[g]     = int'($urandom_range(3, 0));
          starts[g]++;
          if (ma_w[g] < 8'd16) a_hist[g][ma_w[g][3:0]]++;
          else oor++;
        end else if (spur_en && $urandom_range(1, 0) == 1) begin
          mval[g] = 1'b1;
          mres[g] = 8'($urandom);
        end
      end
    end
  end

  task automatic run_op(input string tag, input logic [31:0] c, input logic i, input bit disturb);
    int          s0 [2];
    int          v0 [2];
    int          h0 [2][16];
    logic [31:0] exp;
    logic [15:0] mask;
    bit          iv;
    int          n;
    iv  = InvEn ? i : 1'b0;
    exp = ref_mix(c, iv);
    for (int g = 0; g < 2; g++) begin
      s0[g] = starts[g];
      v0[g] = valids[g];
      for (int v = 0; v < 16; v++) h0[g][v] = a_hist[g][v];
    end
    @(negedge clk);
    start = 1'b1;
    col   = c;
    inv   = i;
    @(negedge clk);
    start = 1'b0;
    col   = $urandom;
    inv   = 1'($urandom);
    #1;
    for (int g = 0; g < 2; g++) check_eq($sformatf("%s_busy_rise%0d", tag, g), 32'(busy_w[g]), 1);
    if (disturb) begin
      spur_en = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b1;
      col   = $urandom;
      inv   = ~i;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (n < 600 && !((valids[0] - v0[0]) >= 1 && (valids[1] - v0[1]) >= 1)) begin
      @(negedge clk);
      #1;
      n++;
    end
    spur_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      mask = 16'h0;
      for (int v = 0; v < 16; v++) if (a_hist[g][v] != h0[g][v]) mask[v] = 1'b1;
      check_eq($sformatf("%s_col%0d", tag, g), col_w[g], exp);
      check_eq($sformatf("%s_nvalid%0d", tag, g), valids[g] - v0[g], 1);
      check_eq($sformatf("%s_busy_fall%0d", tag, g), 32'(busy_w[g]), 0);
      check_eq($sformatf("%s_nstart%0d", tag, g), starts[g] - s0[g], exp_starts(g == 1, iv));
      check_eq($sformatf("%s_amask%0d", tag, g), 32'(mask), 32'(exp_mask(g == 1, iv)));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("%s_col%0d", tag, g), col_w[g], 0);
      check_eq($sformatf("%s_ctl%0d", tag, g),
               {valid_w[g], busy_w[g], mstart_w[g], ma_w[g], mb_w[g]}, 0);
    end
  endtask

  initial begin
    int s0;
    int n;
    n_tests  = 0;
    n_fail   = 0;
    spur_en  = 1'b0;
    overlap  = 0;
    unstable = 0;
    oor      = 0;
    for (int g = 0; g < 2; g++) begin
      starts[g] = 0;
      valids[g] = 0;
      lat[g]    = 0;
      pa[g]     = 8'h00;
      pb[g]     = 8'h00;
      for (int v = 0; v < 16; v++) a_hist[g][v] = 0;
    end
    start = 1'b0;
    inv   = 1'b0;
    col   = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_op("t1", 32'hDB135345, 1'b0, 1'b0);
    check_eq("t1_known", col_w[0], 32'h8E4DA1BC);
    run_op("t2a", 32'hD4BF5D30, 1'b0, 1'b0);
    check_eq("t2a_known", col_w[1], 32'h046681E5);
    run_op("t2b", 32'hF20A225C, 1'b0, 1'b0);
    check_eq("t2b_known", col_w[0], 32'h9FDC589D);
    run_op("t3", 32'hC6C6C6C6, 1'b0, 1'b0);
    run_op("t4", 32'h8E4DA1BC, 1'b1, 1'b0);
    if (InvEn) check_eq("t4_known", col_w[0], 32'hDB135345);
    run_op("t5", 32'hDB135345, 1'b0, 1'b1);
    check_eq("t5_known", col_w[1], 32'h8E4DA1BC);

    for (int t = 0; t < 6; t++)
      run_op($sformatf("rnd%0d", t), $urandom, 1'($urandom), 1'($urandom));

    // Reset while the non-bypass engine waits on its first row-2 product.
    s0 = starts[0];
    @(negedge clk);
    start = 1'b1;
    col   = 32'h3A7F0C91;
    inv   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 400 && !((starts[0] - s0) == 9 && pending[0])) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("t6_reach_row2", starts[0] - s0, 9);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_op("t6", 32'h01010101, 1'b0, 1'b0);

    check_eq("overlap", overlap, 0);
    check_eq("unstable", unstable, 0);
    check_eq("a_range", oor, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
